// File: rtl/ps2_cmd_decoder.sv
// PS/2 keyboard command front-end: synchronises the pins, receives 11-bit frames,
// tracks E0/F0 prefixes, maps scan codes to instruction indices and queues them.
module ps2_cmd_decoder #(
  parameter int unsigned             NUM_CMDS     = 5,
  parameter int unsigned             INSTR_W      = 3,
  parameter logic [8*NUM_CMDS-1:0]   CMD_CODES    = {8'h6B, 8'h7A, 8'h72, 8'h69, 8'h70},
  parameter bit                      EMIT_ON_MAKE = 1'b0,
  parameter int unsigned             FIFO_DEPTH   = 4,
  parameter int unsigned             SYNC_STAGES  = 2,
  parameter int unsigned             TIMEOUT_CYC  = 5000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ps2_clk,
  input  logic                         ps2_data,
  input  logic                         enable,
  output logic [INSTR_W-1:0]           instr_data,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         frame_err,
  output logic                         overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  // Pin synchronisers; idle-high reset value avoids a spurious fall after reset
  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_d;
  logic                   clk_s, data_s, fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_d     <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_d     <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_d & ~clk_s;

  logic [1:0]      state, state_n;
  logic [7:0]      shift, shift_n;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic            par_ok, par_ok_n;
  logic [TO_W-1:0] tcnt, tcnt_n;
  logic            byte_valid, byte_valid_n;
  logic            frame_err_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      par_ok     <= 1'b0;
      tcnt       <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      shift      <= shift_n;
      bit_cnt    <= bit_cnt_n;
      par_ok     <= par_ok_n;
      tcnt       <= tcnt_n;
      byte_valid <= byte_valid_n;
      frame_err  <= frame_err_n;
    end
  end

  // Frame receiver: start, 8 data bits LSB first, odd parity, stop; plus timeout abort
  always_comb begin
    state_n      = state;
    shift_n      = shift;
    bit_cnt_n    = bit_cnt;
    par_ok_n     = par_ok;
    byte_valid_n = 1'b0;
    frame_err_n  = 1'b0;
    tcnt_n       = tcnt;

    if (state == ST_IDLE || fall) tcnt_n = '0;
    else                          tcnt_n = tcnt + TO_W'(1);

    case (state)
      ST_IDLE: begin
        if (fall && !data_s) begin
          state_n   = ST_DATA;
          bit_cnt_n = '0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_n   = {data_s, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_ok_n = ^{shift, data_s};
          state_n  = ST_STOP;
        end
      end
      default: begin
        if (fall) begin
          state_n = ST_IDLE;
          if (data_s && par_ok) byte_valid_n = 1'b1;
          else                  frame_err_n  = 1'b1;
        end
      end
    endcase

    if (state != ST_IDLE && !fall && tcnt == TO_W'(TIMEOUT_CYC - 1)) begin
      state_n     = ST_IDLE;
      frame_err_n = 1'b1;
      tcnt_n      = '0;
    end
  end

  // Scan-code table lookup, lowest index wins
  logic               hit;
  logic [INSTR_W-1:0] hit_idx;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < int'(NUM_CMDS); i++) begin
      if (!hit && CMD_CODES[8*i +: 8] == shift) begin
        hit     = 1'b1;
        hit_idx = INSTR_W'(i);
      end
    end
  end

  logic       ext, brk;
  logic [7:0] last_make;
  logic       last_vld;
  logic       is_code, emit;

  assign is_code = byte_valid && shift != CODE_EXT && shift != CODE_BRK;

  always_comb begin
    emit = 1'b0;
    if (is_code && !ext && hit) begin
      if (EMIT_ON_MAKE) emit = !brk && !(last_vld && last_make == shift);
      else              emit = brk;
    end
  end

  logic               push_q;
  logic [INSTR_W-1:0] push_instr;

  // Prefix tracking and repeat suppression; push request lands the cycle after byte_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext        <= 1'b0;
      brk        <= 1'b0;
      last_make  <= '0;
      last_vld   <= 1'b0;
      push_q     <= 1'b0;
      push_instr <= '0;
    end else begin
      push_q     <= emit & enable;
      push_instr <= hit_idx;
      if (frame_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_valid) begin
        if (shift == CODE_EXT) begin
          ext <= 1'b1;
        end else if (shift == CODE_BRK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (!ext) begin
            if (!brk) begin
              last_make <= shift;
              last_vld  <= 1'b1;
            end else if (last_vld && last_make == shift) begin
              last_vld  <= 1'b0;
            end
          end
        end
      end
    end
  end

  // Instruction FIFO; head registers show only entries already stored
  logic [INSTR_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, rd_next;
  logic [CNT_W-1:0]   count_n;
  logic               pop, full, do_push, avail;

  assign pop     = instr_valid & instr_ready;
  assign full    = fifo_count == CNT_W'(FIFO_DEPTH);
  assign do_push = push_q & (!full | pop);
  assign avail   = (fifo_count - CNT_W'(pop)) != '0;
  assign rd_next = rd_ptr + PTR_W'(pop);

  always_comb begin
    count_n = fifo_count;
    if (do_push && !pop)      count_n = fifo_count + CNT_W'(1);
    else if (!do_push && pop) count_n = fifo_count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_instr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      instr_valid <= 1'b0;
      instr_data  <= '0;
      overflow    <= 1'b0;
    end else begin
      overflow    <= push_q & full & !pop;
      fifo_count  <= count_n;
      instr_valid <= avail;
      instr_data  <= avail ? mem[rd_next] : '0;
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_next;
    end
  end

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// Directed bench for ps2_cmd_decoder: break-mode and make-mode instances share the PS/2 pins.
module tb_ps2_cmd_decoder;

  localparam int HALF = 10;
  localparam int TO   = 5000;

  logic       clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic       enable = 1'b1, instr_ready = 1'b1;
  logic [2:0] d0, d1, c0, c1;
  logic       v0, v1, e0, e1, o0, o1;

  int total = 0, bad = 0;
  int cyc = 0, fall_cyc = 0, rise_cyc = -1, err_cyc = -1;
  int err0 = 0, err1 = 0, ovf0 = 0, ovf1 = 0;
  logic v0_q = 1'b0;
  logic [2:0] q0[$], q1[$];

  ps2_cmd_decoder #(.EMIT_ON_MAKE(1'b0)) dut_brk (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .enable(enable),
    .instr_data(d0), .instr_valid(v0), .instr_ready(instr_ready), .fifo_count(c0),
    .frame_err(e0), .overflow(o0));

  ps2_cmd_decoder #(.EMIT_ON_MAKE(1'b1)) dut_make (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .enable(1'b1),
    .instr_data(d1), .instr_valid(v1), .instr_ready(1'b1), .fifo_count(c1),
    .frame_err(e1), .overflow(o1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record accepted instructions and pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (v0 && instr_ready) q0.push_back(d0);
    if (v1) q1.push_back(d1);
    if (v0 && !v0_q) rise_cyc = cyc;
    v0_q = v0;
    if (e0) begin err0++; err_cyc = cyc; end
    if (e1) err1++;
    if (o0) ovf0++;
    if (o1) ovf1++;
  end

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk); ps2_data = bits[k];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0; fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (2*HALF) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
  endtask

  task automatic settle;
    repeat (30) @(negedge clk);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk); #1 instr_ready = r;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if ({v0, d0, c0, e0, o0} !== 9'd0) begin
      bad++; $display("FAIL reset_hold: got %b want 0", {v0, d0, c0, e0, o0});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if ({v0, d0, c0, e0, o0} !== 9'd0) begin
      bad++; $display("FAIL reset_release: got %b want 0", {v0, d0, c0, e0, o0});
    end
  endtask

  task automatic test_break_emit;
    q0.delete(); q1.delete();
    send(8'h70); settle();
    total++;
    if (q0.size() != 0) begin
      bad++; $display("FAIL make_silent: got n=%0d want n=0", q0.size());
    end
    send(8'hF0);
    rise_cyc = -1;
    send(8'h70); settle();
    total++;
    if (rise_cyc - fall_cyc < 6 || rise_cyc - fall_cyc > 7) begin
      bad++; $display("FAIL latency: got %0d want 6..7", rise_cyc - fall_cyc);
    end
    total++;
    if (q0.size() != 1 || q0[0] !== 3'd0) begin
      bad++; $display("FAIL break_emit: got n=%0d first=%0d want n=1 instr=0", q0.size(), (q0.size() > 0) ? q0[0] : 3'd7);
    end
    total++;
    if (q1.size() != 1 || q1[0] !== 3'd0) begin
      bad++; $display("FAIL make_inst_first: got n=%0d first=%0d want n=1 instr=0", q1.size(), (q1.size() > 0) ? q1[0] : 3'd7);
    end
  endtask

  task automatic test_make_mode;
    q0.delete(); q1.delete(); ovf1 = 0;
    send(8'h72); send(8'h72); send(8'h72); settle();
    total++;
    if (q1.size() != 1) begin
      bad++; $display("FAIL typematic: got n=%0d want n=1", q1.size());
    end
    send(8'hF0); send(8'h72); send(8'h72); settle();
    total++;
    if (q1.size() != 2 || q1[0] !== 3'd2 || q1[1] !== 3'd2) begin
      bad++; $display("FAIL make_mode: got n=%0d want n=2 of instr 2", q1.size());
    end
    total++;
    if (q0.size() != 1 || q0[0] !== 3'd2) begin
      bad++; $display("FAIL break_of_72: got n=%0d want n=1 instr=2", q0.size());
    end
    total++;
    if (c1 !== 3'd0 || ovf1 != 0) begin
      bad++; $display("FAIL make_drain: got count=%0d ovf=%0d want 0 0", c1, ovf1);
    end
  endtask

  task automatic test_parity;
    q0.delete(); err0 = 0; err1 = 0;
    send_frame(8'h69, 1'b1, 11); settle();
    total++;
    if (err0 != 1 || err1 != 1) begin
      bad++; $display("FAIL parity_err: got %0d/%0d pulses want 1/1", err0, err1);
    end
    total++;
    if (q0.size() != 0) begin
      bad++; $display("FAIL parity_noinstr: got n=%0d want 0", q0.size());
    end
    send(8'hF0); send(8'h69); settle();
    total++;
    if (q0.size() != 1 || q0[0] !== 3'd1 || err0 != 1) begin
      bad++; $display("FAIL after_parity: got n=%0d err=%0d want n=1 instr=1 err=1", q0.size(), err0);
    end
  endtask

  task automatic test_overflow_drain;
    bit ok;
    set_ready(1'b0);
    q0.delete(); ovf0 = 0;
    send(8'hF0); send(8'h70); send(8'hF0); send(8'h69);
    send(8'hF0); send(8'h72); send(8'hF0); send(8'h7A); settle();
    total++;
    if (c0 !== 3'd4 || v0 !== 1'b1 || d0 !== 3'd0) begin
      bad++; $display("FAIL fill: got count=%0d valid=%0b head=%0d want 4 1 0", c0, v0, d0);
    end
    send(8'hF0); send(8'h6B); settle();
    total++;
    if (ovf0 != 1 || c0 !== 3'd4 || d0 !== 3'd0) begin
      bad++; $display("FAIL overflow: got ovf=%0d count=%0d head=%0d want 1 4 0", ovf0, c0, d0);
    end
    set_ready(1'b1);
    repeat (10) @(negedge clk);
    ok = (q0.size() == 4);
    for (int i = 0; i < 4; i++) if (ok && q0[i] !== 3'(i)) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++; $display("FAIL drain_order: got n=%0d want 0,1,2,3", q0.size());
    end
    total++;
    if (c0 !== 3'd0 || v0 !== 1'b0) begin
      bad++; $display("FAIL drain_empty: got count=%0d valid=%0b want 0 0", c0, v0);
    end
  endtask

  task automatic test_timeout;
    int waited;
    err0 = 0; err_cyc = -1; q0.delete();
    send_frame(8'h7A, 1'b0, 5);
    waited = 0;
    while (err0 == 0 && waited < TO + 100) begin
      @(negedge clk); waited++;
    end
    total++;
    if (err0 != 1) begin
      bad++; $display("FAIL timeout_pulse: got %0d pulses want 1", err0);
    end
    total++;
    if (err_cyc - fall_cyc < TO || err_cyc - fall_cyc > TO + 10) begin
      bad++; $display("FAIL timeout_delay: got %0d want %0d..%0d", err_cyc - fall_cyc, TO, TO + 10);
    end
    send(8'hF0); send(8'h7A); settle();
    total++;
    if (q0.size() != 1 || q0[0] !== 3'd3) begin
      bad++; $display("FAIL after_timeout: got n=%0d want n=1 instr=3", q0.size());
    end
  endtask

  task automatic test_prefix_enable;
    q0.delete();
    send(8'hE0); send(8'hF0); send(8'h70); settle();
    total++;
    if (q0.size() != 0) begin
      bad++; $display("FAIL extended: got n=%0d want 0", q0.size());
    end
    @(posedge clk); #1 enable = 1'b0;
    send(8'hF0); send(8'h6B); settle();
    total++;
    if (q0.size() != 0 || c0 !== 3'd0) begin
      bad++; $display("FAIL disabled: got n=%0d count=%0d want 0 0", q0.size(), c0);
    end
    @(posedge clk); #1 enable = 1'b1;
    send(8'hF0); send(8'h6B); settle();
    total++;
    if (q0.size() != 1 || q0[0] !== 3'd4) begin
      bad++; $display("FAIL reenabled: got n=%0d want n=1 instr=4", q0.size());
    end
  endtask

  task automatic test_reset_midframe;
    set_ready(1'b0);
    send(8'hF0); send(8'h70); settle();
    total++;
    if (c0 !== 3'd1) begin
      bad++; $display("FAIL pre_reset_count: got %0d want 1", c0);
    end
    send_frame(8'h69, 1'b0, 4);
    @(negedge clk); rst_n = 1'b0;
    #1;
    total++;
    if ({v0, d0, c0, e0, o0} !== 9'd0) begin
      bad++; $display("FAIL async_reset: got %b want 0", {v0, d0, c0, e0, o0});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    set_ready(1'b1);
    q0.delete();
    send(8'hF0); send(8'h69); settle();
    total++;
    if (q0.size() != 1 || q0[0] !== 3'd1) begin
      bad++; $display("FAIL post_reset: got n=%0d want n=1 instr=1", q0.size());
    end
  endtask

  initial begin
    test_reset();
    test_break_emit();
    test_make_mode();
    test_parity();
    test_overflow_drain();
    test_timeout();
    test_prefix_enable();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
